sub_rs_queue: RTL and testbench
===============================

Name: sub_rs_queue

Overview:
- Reservation-station queue for the Sub execution unit; sits directly upstream of it.
- Accepts dispatched subtract ops whose operands may still be pending on tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Each cycle, issues the oldest fully-ready entry to the Sub unit as a registered busy/value1/value2 bundle with both tags zero.

Parameters:
- DEPTH, 4, number of entries (2..16).
- TAG_W, 8, width of operand/destination tags; tag 0 = "value present".
- DATA_W, 32, operand width.

Ports:
- clk  in  1  clock.
- RSTN_N  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries and of the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals (count < DEPTH).
- disp_dest  in  TAG_W  destination tag of the op.
- disp_alu1  in  TAG_W  source-1 tag; 0 = disp_value1 is valid.
- disp_value1  in  DATA_W  source-1 value.
- disp_alu2  in  TAG_W  source-2 tag; 0 = disp_value2 is valid.
- disp_value2  in  DATA_W  source-2 value.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  DATA_W  broadcast value.
- issue_valid  out  1  drives Sub busy; tags to Sub tied 0.
- issue_dest  out  TAG_W  destination tag of the issued op.
- issue_value1  out  DATA_W  minuend.
- issue_value2  out  DATA_W  subtrahend.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, RSTN_N low): all entries invalid; count=0; issue_valid=0; issue_dest/value1/value2=0. Reset mid-operation discards all contents.
- Storage: collapsing queue; entry 0 is the oldest. Each entry holds dest, tag1, val1, tag2, val2.
- Entry ready: both tags == 0 in the registered state.
- Issue, per posedge:
  - Select the lowest-index ready entry.
  - If one exists: issue_valid<=1 and outputs <= entry fields; remove the entry; higher entries shift down one slot.
  - If none exists: issue_valid<=0 and outputs <= 0.
  - At most one issue per cycle; no backpressure, because Sub accepts every cycle.
- Dispatch: accepted when disp_valid && disp_ready. The new entry is written at the tail after any same-cycle shift (index count-1 if issuing, else count). disp_ready is computed from registered count only, so a full queue refuses dispatch even in a cycle where it issues.
- CDB capture (cdb_valid && cdb_tag != 0):
  - Every stored entry with tagN == cdb_tag: valN <= cdb_value, tagN <= 0.
  - Applies to both operands independently.
  - Applies to entries that shift in the same cycle; the shifted entry lands with captured values.
- Dispatch bypass: if an accepted dispatch has disp_aluN == cdb_tag (nonzero, cdb_valid), that operand is stored as cdb_value with tag 0.
- cdb_valid with cdb_tag == 0 is ignored.
- Latency:
  - Dispatch with both tags 0 at edge N -> issue_valid high after edge N+1 (if oldest ready).
  - CDB wake-up at edge N -> issue after edge N+1.
- flush: at the next edge clears all entries, count=0, issue_valid=0, outputs 0. Dispatch and capture in that cycle are ignored. flush has priority over everything except reset.
- count: +1 on accept, −1 on issue, unchanged on both or neither.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry with exactly the outstanding tag(s) matching the current CDB broadcast counts as ready this cycle.
  - It issues at the same edge, with cdb_value substituted for the pending operand(s).
  - Age priority is still applied over the combined ready set.
  - Wake-up-to-issue latency becomes 0 extra cycles.
- Undefined: readiness uses registered tags only, as above.

Test Plan:
- Reset, then dispatch dest=5, (alu1=0, v1=10), (alu2=0, v2=3) at edge 1 -> issue_valid=1, issue_dest=5, value1=10, value2=3 after edge 2; issue_valid=0 after edge 3; count returns to 0.
- Dispatch dest=6 with alu1=9 pending, v2=4 ready; hold 3 cycles with no issue; CDB tag=9 value=20 -> issue value1=20, value2=4 one edge later (same edge with RS_WAKEUP_BYPASS_EN).
- Fill 4 pending entries -> disp_ready=0 and a 5th dispatch is dropped. Wake entry 2 only -> entry 2 issues and entries 3 shift to 2. The next dispatch lands at index 3; order is preserved.
- Dispatch alu1=7 on the same cycle as CDB tag=7 value=0xFFFF_FFFF -> stored ready, issued with value1=0xFFFF_FFFF.
- Two ready entries (dest=1 older, dest=2) -> dest=1 issues first, dest=2 on the following edge.
- Assert flush with 3 entries plus a concurrent dispatch, and separately RSTN_N low mid-stream -> count=0 and issue_valid=0 after the edge (immediately for reset); no stale issue follows.

Source files
------------

// File: rtl/sub_rs_queue.sv
// Reservation-station queue for the Sub unit: a collapsing, age-ordered queue that snoops the CDB and issues the oldest ready op.
// Optional macro RS_WAKEUP_BYPASS_EN lets an entry woken by the current CDB broadcast issue in that same cycle.
module sub_rs_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       RSTN_N,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [TAG_W-1:0]           disp_dest,
    input  logic [TAG_W-1:0]           disp_alu1,
    input  logic [DATA_W-1:0]          disp_value1,
    input  logic [TAG_W-1:0]           disp_alu2,
    input  logic [DATA_W-1:0]          disp_value2,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    output logic                       issue_valid,
    output logic [TAG_W-1:0]           issue_dest,
    output logic [DATA_W-1:0]          issue_value1,
    output logic [DATA_W-1:0]          issue_value2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] val1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val2;
    } entry_t;

    entry_t             ent_reg  [DEPTH];
    entry_t             ent_cap  [DEPTH];
    entry_t             ent_next [DEPTH];
    logic [DEPTH-1:0]   ready;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue_any;
    logic               cdb_hit;
    logic               accept;
    entry_t             disp_ent;
    entry_t             iss_ent;

    logic               issue_valid_reg;
    logic [TAG_W-1:0]   issue_dest_reg;
    logic [DATA_W-1:0]  issue_value1_reg;
    logic [DATA_W-1:0]  issue_value2_reg;

    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign disp_ready = (count_reg < CNT_W'(DEPTH));
    assign accept     = disp_valid && disp_ready;
    assign wr_idx     = count_reg - CNT_W'(issue_any);

    // Incoming op picks up a value broadcast in the same cycle it is dispatched.
    always_comb begin
        disp_ent.dest = disp_dest;
        disp_ent.tag1 = disp_alu1;
        disp_ent.val1 = disp_value1;
        disp_ent.tag2 = disp_alu2;
        disp_ent.val2 = disp_value2;
        if (cdb_hit && disp_alu1 == cdb_tag) begin
            disp_ent.tag1 = '0;
            disp_ent.val1 = cdb_value;
        end
        if (cdb_hit && disp_alu2 == cdb_tag) begin
            disp_ent.tag2 = '0;
            disp_ent.val2 = cdb_value;
        end
    end

    function automatic entry_t capture(input entry_t e, input logic hit,
                                       input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] value);
        entry_t r;
        r = e;
        if (hit && e.tag1 == tag) begin
            r.tag1 = '0;
            r.val1 = value;
        end
        if (hit && e.tag2 == tag) begin
            r.tag2 = '0;
            r.val2 = value;
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            entry_t shifted;

            assign ent_cap[gi] = capture(ent_reg[gi], cdb_hit, cdb_tag, cdb_value);

`ifdef RS_WAKEUP_BYPASS_EN
            assign ready[gi] = (CNT_W'(gi) < count_reg) &&
                               (ent_cap[gi].tag1 == '0) && (ent_cap[gi].tag2 == '0);
`else
            assign ready[gi] = (CNT_W'(gi) < count_reg) &&
                               (ent_reg[gi].tag1 == '0) && (ent_reg[gi].tag2 == '0);
`endif

            if (gi < DEPTH - 1) begin : g_mid
                assign shifted = ent_cap[gi+1];
            end else begin : g_last
                assign shifted = ent_cap[gi];
            end

            // Tail write wins over shift: the slot at wr_idx is vacated by the issue.
            assign ent_next[gi] = (accept && wr_idx == CNT_W'(gi)) ? disp_ent :
                                  (issue_any && sel_idx <= IDX_W'(gi)) ? shifted :
                                  ent_cap[gi];
        end
    endgenerate

    // Lowest index wins, so scan from the top down.
    always_comb begin
        issue_any = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_any = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign iss_ent = ent_cap[sel_idx];

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
            count_reg        <= '0;
            issue_valid_reg  <= 1'b0;
            issue_dest_reg   <= '0;
            issue_value1_reg <= '0;
            issue_value2_reg <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
            count_reg        <= '0;
            issue_valid_reg  <= 1'b0;
            issue_dest_reg   <= '0;
            issue_value1_reg <= '0;
            issue_value2_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= ent_next[i];
            end
            count_reg       <= count_reg + CNT_W'(accept) - CNT_W'(issue_any);
            issue_valid_reg <= issue_any;
            if (issue_any) begin
                issue_dest_reg   <= iss_ent.dest;
                issue_value1_reg <= iss_ent.val1;
                issue_value2_reg <= iss_ent.val2;
            end else begin
                issue_dest_reg   <= '0;
                issue_value1_reg <= '0;
                issue_value2_reg <= '0;
            end
        end
    end

    assign issue_valid  = issue_valid_reg;
    assign issue_dest   = issue_dest_reg;
    assign issue_value1 = issue_value1_reg;
    assign issue_value2 = issue_value2_reg;
    assign count        = count_reg;

endmodule

// File: tb/tb_sub_rs_queue.sv
// Bench for sub_rs_queue: directed scenarios plus random traffic, all checked against a queue-based reference model.
module tb_sub_rs_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        RSTN_N;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [7:0]  disp_dest;
    logic [7:0]  disp_alu1;
    logic [31:0] disp_value1;
    logic [7:0]  disp_alu2;
    logic [31:0] disp_value2;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        issue_valid;
    logic [7:0]  issue_dest;
    logic [31:0] issue_value1;
    logic [31:0] issue_value2;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  dest;
        logic [7:0]  t1;
        logic [31:0] v1;
        logic [7:0]  t2;
        logic [31:0] v2;
    } ment_t;

    ment_t       mq[$];
    logic        exp_valid;
    logic [7:0]  exp_dest;
    logic [31:0] exp_v1;
    logic [31:0] exp_v2;

    sub_rs_queue #(.DEPTH(DEPTH), .TAG_W(8), .DATA_W(32)) dut (
        .clk(clk), .RSTN_N(RSTN_N), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_dest(disp_dest),
        .disp_alu1(disp_alu1), .disp_value1(disp_value1),
        .disp_alu2(disp_alu2), .disp_value2(disp_value2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_value1(issue_value1), .issue_value2(issue_value2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("issue_valid", 64'(issue_valid), 64'(exp_valid));
        chk("issue_dest", 64'(issue_dest), 64'(exp_dest));
        chk("issue_value1", 64'(issue_value1), 64'(exp_v1));
        chk("issue_value2", 64'(issue_value2), 64'(exp_v2));
        chk("count", 64'(count), 64'(mq.size()));
        chk("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
    endtask

    // One clock: drive inputs, advance the model by the queue rules, check after the edge.
    task automatic step(input bit dv, input logic [7:0] dd,
                        input logic [7:0] a1, input logic [31:0] v1,
                        input logic [7:0] a2, input logic [31:0] v2,
                        input bit cv, input logic [7:0] ct, input logic [31:0] cval,
                        input bit fl);
        int    pick;
        bit    acc;
        bit    rdy;
        bit    hit;
        ment_t e;
        disp_valid = dv; disp_dest = dd; disp_alu1 = a1; disp_value1 = v1;
        disp_alu2 = a2; disp_value2 = v2;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; flush = fl;

        acc  = dv && (mq.size() < DEPTH);
        hit  = cv && (ct != 8'd0);
        pick = -1;
        exp_valid = 1'b0; exp_dest = '0; exp_v1 = '0; exp_v2 = '0;
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                rdy = (e.t1 == 8'd0) && (e.t2 == 8'd0);
                if (hit && e.t1 == ct) begin e.t1 = 8'd0; e.v1 = cval; end
                if (hit && e.t2 == ct) begin e.t2 = 8'd0; e.v2 = cval; end
`ifdef RS_WAKEUP_BYPASS_EN
                rdy = (e.t1 == 8'd0) && (e.t2 == 8'd0);
`endif
                mq[i] = e;
                if (rdy && pick < 0) pick = i;
            end
            if (pick >= 0) begin
                exp_valid = 1'b1;
                exp_dest  = mq[pick].dest;
                exp_v1    = mq[pick].v1;
                exp_v2    = mq[pick].v2;
                mq.delete(pick);
            end
            if (acc) begin
                e.dest = dd; e.t1 = a1; e.v1 = v1; e.t2 = a2; e.v2 = v2;
                if (hit && a1 == ct) begin e.t1 = 8'd0; e.v1 = cval; end
                if (hit && a2 == ct) begin e.t2 = 8'd0; e.v2 = cval; end
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_model();
        if (issue_valid)
            $display("[TB] t=%0t issue dest=%0d v1=%0h v2=%0h count=%0d", $time,
                     issue_dest, issue_value1, issue_value2, count);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic disp(input logic [7:0] dd, input logic [7:0] a1, input logic [31:0] v1,
                        input logic [7:0] a2, input logic [31:0] v2);
        step(1, dd, a1, v1, a2, v2, 0, 0, 0, 0);
    endtask

    task automatic wake(input logic [7:0] ct, input logic [31:0] cval);
        step(0, 0, 0, 0, 0, 0, 1, ct, cval, 0);
`ifndef RS_WAKEUP_BYPASS_EN
        idle();
`endif
    endtask

    initial begin
        RSTN_N = 1'b0; flush = 0; disp_valid = 0; disp_dest = 0; disp_alu1 = 0;
        disp_value1 = 0; disp_alu2 = 0; disp_value2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        exp_valid = 0; exp_dest = 0; exp_v1 = 0; exp_v2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_issue_valid", 64'(issue_valid), 64'd0);
        chk("reset_issue_dest", 64'(issue_dest), 64'd0);
        RSTN_N = 1'b1;
        idle();

        // Ready op: issues one edge after dispatch, then the slot drains.
        disp(8'd5, 8'd0, 32'd10, 8'd0, 32'd3);
        chk("ready_not_yet", 64'(issue_valid), 64'd0);
        idle();
        chk("ready_dest", 64'(issue_dest), 64'd5);
        chk("ready_v1", 64'(issue_value1), 64'd10);
        chk("ready_v2", 64'(issue_value2), 64'd3);
        idle();
        chk("ready_drained", 64'(issue_valid), 64'd0);
        chk("ready_count0", 64'(count), 64'd0);

        // Pending operand held until CDB wake-up.
        disp(8'd6, 8'd9, 32'd0, 8'd0, 32'd4);
        repeat (3) idle();
        chk("pending_held", 64'(issue_valid), 64'd0);
        wake(8'd9, 32'd20);
        chk("wake_dest", 64'(issue_dest), 64'd6);
        chk("wake_v1", 64'(issue_value1), 64'd20);
        chk("wake_v2", 64'(issue_value2), 64'd4);
        idle();

        // Full queue refuses a fifth op; waking the middle entry collapses the queue.
        disp(8'd21, 8'd11, 32'd0, 8'd0, 32'd1);
        disp(8'd22, 8'd12, 32'd0, 8'd0, 32'd2);
        disp(8'd23, 8'd13, 32'd0, 8'd0, 32'd3);
        disp(8'd24, 8'd14, 32'd0, 8'd0, 32'd4);
        chk("full_ready", 64'(disp_ready), 64'd0);
        disp(8'd25, 8'd0, 32'd5, 8'd0, 32'd5);
        chk("full_dropped", 64'(count), 64'd4);
        wake(8'd13, 32'h100);
        chk("mid_dest", 64'(issue_dest), 64'd23);
        chk("mid_v1", 64'(issue_value1), 64'h100);
        disp(8'd26, 8'd15, 32'd0, 8'd0, 32'd6);
        wake(8'd11, 32'h111);
        wake(8'd12, 32'h122);
        wake(8'd14, 32'h144);
        chk("order_dest24", 64'(issue_dest), 64'd24);
        wake(8'd15, 32'h155);
        chk("order_dest26", 64'(issue_dest), 64'd26);
        idle();

        // Dispatch-time bypass from the CDB.
        step(1, 8'd40, 8'd7, 32'd0, 8'd0, 32'd2, 1, 8'd7, 32'hFFFF_FFFF, 0);
        idle();
        chk("bypass_dest", 64'(issue_dest), 64'd40);
        chk("bypass_v1", 64'(issue_value1), 64'hFFFF_FFFF);
        idle();

        // Two entries woken together issue oldest first.
        disp(8'd1, 8'd30, 32'd0, 8'd0, 32'd1);
        disp(8'd2, 8'd30, 32'd0, 8'd0, 32'd2);
        wake(8'd30, 32'd50);
        chk("age_first", 64'(issue_dest), 64'd1);
        idle();
        chk("age_second", 64'(issue_dest), 64'd2);
        idle();

        // Flush with a concurrent dispatch.
        disp(8'd60, 8'd31, 32'd0, 8'd0, 32'd0);
        disp(8'd61, 8'd32, 32'd0, 8'd0, 32'd0);
        disp(8'd62, 8'd33, 32'd0, 8'd0, 32'd0);
        step(1, 8'd63, 8'd0, 32'd1, 8'd0, 32'd1, 1, 8'd31, 32'd9, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(issue_valid), 64'd0);
        idle();
        chk("flush_no_stale", 64'(issue_valid), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 1) == 1, 8'($urandom_range(1, 255)),
                 ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 7)), $urandom,
                 ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 8'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-stream.
        disp(8'd70, 8'd0, 32'd1, 8'd0, 32'd1);
        disp(8'd71, 8'd0, 32'd2, 8'd0, 32'd2);
        #2;
        RSTN_N = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_valid", 64'(issue_valid), 64'd0);
        mq.delete();
        exp_valid = 1'b0; exp_dest = '0; exp_v1 = '0; exp_v2 = '0;
        disp_valid = 0; cdb_valid = 0; flush = 0;
        @(posedge clk);
        #1;
        RSTN_N = 1'b1;
        idle();
        chk("areset_no_stale", 64'(issue_valid), 64'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
